// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned OFFSET_W        = 4;
  localparam int unsigned BLOCK_ADDR_W    = ADDR_W - OFFSET_W;
  localparam int unsigned BYTES_PER_WORD  = WORD_W / 8;
  localparam int unsigned WORD_SEL_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    UPDATE
  } state_t;

  // Word-in-line select, byte-lane bits dropped.
  function automatic logic [WORD_SEL_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:2];
  endfunction

  // Block address: byte address with the in-line offset removed.
  function automatic logic [BLOCK_ADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

  // Tag portion of a block address for a cache with idx_w index bits.
  function automatic logic [BLOCK_ADDR_W-1:0] block_tag(input logic [BLOCK_ADDR_W-1:0] block,
                                                        input int unsigned idx_w);
    return block >> idx_w;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the data cache: valid/dirty/tag/data arrays with tag compare,
// word read, byte-masked word write and full-line fill.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned TAG_W = 25,
  localparam int unsigned IDX  = $clog2(LINES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [IDX-1:0]            index,
  input  logic [TAG_W-1:0]          tag,
  input  logic [WORD_SEL_W-1:0]     offset,
  output logic                      hit_c,
  output logic                      line_valid_c,
  output logic                      line_dirty_c,
  output logic [TAG_W-1:0]          line_tag_c,
  output logic [BLOCK_W-1:0]        line_data_c,
  output logic [WORD_W-1:0]         read_word_c,
  input  logic                      write_en,
  input  logic [WORD_W-1:0]         write_data,
  input  logic [BYTES_PER_WORD-1:0] write_byteen,
  input  logic                      fill_en,
  input  logic [BLOCK_W-1:0]        fill_data,
  input  logic                      update_en
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Status bits clear on reset; a line becomes clean+valid when its new tag lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (update_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (write_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid gates their use.
  always_ff @(posedge clock) begin
    if (update_en) begin
      tag_q[index] <= tag;
    end
    if (fill_en) begin
      data_q[index] <= fill_data;
    end else if (write_en) begin
      for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
        if (write_byteen[k]) begin
          data_q[index][{offset, 2'(k), 3'b000} +: 8] <= write_data[{2'(k), 3'b000} +: 8];
        end
      end
    end
  end

  assign line_valid_c = valid_q[index];
  assign line_dirty_c = dirty_q[index];
  assign line_tag_c   = tag_q[index];
  assign line_data_c  = data_q[index];
  assign hit_c        = valid_q[index] && (tag_q[index] == tag);
  assign read_word_c  = data_q[index][{offset, 5'b00000} +: WORD_W];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller between the
// CPU MEM stage (word + byte enables) and a 128-bit busywait block memory.
module data_cache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned TAG_W = 25
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  input  logic [ADDR_W-1:0]         cpu_address,
  input  logic [WORD_W-1:0]         cpu_writedata,
  input  logic [BYTES_PER_WORD-1:0] cpu_byteen,
  output logic [WORD_W-1:0]         cpu_readdata,
  output logic                      cpu_busywait,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [BLOCK_ADDR_W-1:0]   mem_address,
  output logic [BLOCK_W-1:0]        mem_writedata,
  input  logic [BLOCK_W-1:0]        mem_readdata,
  input  logic                      mem_busywait
);

  localparam int unsigned IDX = $clog2(LINES);

  logic [BLOCK_ADDR_W-1:0] cpu_block;
  logic [IDX-1:0]          index;
  logic [TAG_W-1:0]        tag;
  logic                    access;

  logic                    hit_c;
  logic                    line_valid_c;
  logic                    line_dirty_c;
  logic [TAG_W-1:0]        line_tag_c;
  logic [BLOCK_W-1:0]      line_data_c;

  state_t state_q;
  state_t state_d;
  logic   mem_read_d;
  logic   mem_write_d;
  logic   busy_c;
  logic   write_en;
  logic   fill_en;
  logic   update_en;

  assign cpu_block = addr_block(cpu_address);
  assign index     = cpu_block[IDX-1:0];
  assign tag       = TAG_W'(block_tag(cpu_block, IDX));
  assign access    = cpu_read ^ cpu_write;

  dcache_line_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_line_store (
    .clock        (clock),
    .reset        (reset),
    .index        (index),
    .tag          (tag),
    .offset       (addr_offset(cpu_address)),
    .hit_c        (hit_c),
    .line_valid_c (line_valid_c),
    .line_dirty_c (line_dirty_c),
    .line_tag_c   (line_tag_c),
    .line_data_c  (line_data_c),
    .read_word_c  (cpu_readdata),
    .write_en     (write_en),
    .write_data   (cpu_writedata),
    .write_byteen (cpu_byteen),
    .fill_en      (fill_en),
    .fill_data    (mem_readdata),
    .update_en    (update_en)
  );

  // State and memory request strobes; reset abandons any transfer immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
    end
  end

  // Requests launch on the IDLE miss edge; the WRITEBACK->ALLOCATE hand-off
  // leaves mem_read low for one cycle so the memory sees two distinct accesses.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    busy_c      = 1'b0;
    write_en    = 1'b0;
    fill_en     = 1'b0;
    update_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit_c) begin
            write_en = cpu_write;
          end else begin
            busy_c = 1'b1;
            if (line_valid_c && line_dirty_c) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
            end else begin
              state_d    = ALLOCATE;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      WRITEBACK: begin
        busy_c      = 1'b1;
        mem_write_d = 1'b1;
        if (mem_write && !mem_busywait) begin
          mem_write_d = 1'b0;
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        busy_c     = 1'b1;
        mem_read_d = 1'b1;
        if (mem_read && !mem_busywait) begin
          mem_read_d = 1'b0;
          fill_en    = 1'b1;
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        busy_c    = 1'b1;
        update_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_busywait  = busy_c && !reset;
  assign mem_address   = (state_q == WRITEBACK) ? {line_tag_c, index} : {tag, index};
  assign mem_writedata = line_data_c;

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller: directed CPU accesses against a
// fixed-latency busywait block memory model.
module tb_data_cache_controller;

  localparam int LAT = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_read = 1'b0;
  logic         cpu_write = 1'b0;
  logic [31:0]  cpu_address = '0;
  logic [31:0]  cpu_writedata = '0;
  logic [3:0]   cpu_byteen = '0;
  logic [31:0]  cpu_readdata;
  logic         cpu_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  typedef struct {
    bit           is_write;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_txn_t;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } cpu_txn_t;

  mem_txn_t mem_exp[$];
  cpu_txn_t cpu_exp[$];
  mem_txn_t me;
  cpu_txn_t ce;

  int errors = 0;
  int checks = 0;

  int  mem_cnt = 0;
  logic [127:0] wb_img [256];
  bit  wb_valid [256];

  int  starts = 0, both_cnt = 0, rd_run = 0, rd_last = 0, gap = 0, wb_gap = -1;
  bit  prev_req = 1'b0, after_wr = 1'b0;

  int  busy;
  bit  now;
  int  s;
  bit  seen;

  data_cache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_byteen    (cpu_byteen),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clock = ~clock;

  // Background memory image: byte at byte-address A holds A[7:0].
  function automatic logic [127:0] pattern(input logic [27:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = {blk[3:0], 4'(i)};
    return r;
  endfunction

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < LAT);
  assign mem_readdata = wb_valid[mem_address[7:0]] ? wb_img[mem_address[7:0]] : pattern(mem_address);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: completes a request LAT cycles after it starts; scoreboards it.
  always @(posedge clock) begin
    if (mem_read || mem_write) begin
      if (mem_cnt == LAT) begin
        mem_cnt <= 0;
        checks++;
        if (mem_exp.size() == 0) begin
          errors++;
          $display("FAIL mem_txn: unexpected write=%0d addr=%0h", mem_write, mem_address);
        end else begin
          me = mem_exp.pop_front();
          if (me.is_write != mem_write || me.addr != mem_address ||
              (me.is_write && me.data != mem_writedata)) begin
            errors++;
            $display("FAIL mem_txn: got write=%0d addr=%0h data=%0h expected write=%0d addr=%0h data=%0h",
                     mem_write, mem_address, mem_writedata, me.is_write, me.addr, me.data);
          end
        end
        if (mem_write) begin
          wb_img[mem_address[7:0]]   <= mem_writedata;
          wb_valid[mem_address[7:0]] <= 1'b1;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // CPU response monitor and memory-protocol trackers, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset && (cpu_read ^ cpu_write) && !cpu_busywait) begin
      checks++;
      if (cpu_exp.size() == 0) begin
        errors++;
        $display("FAIL cpu_resp: unexpected completion read=%0d data=%0h", cpu_read, cpu_readdata);
      end else begin
        ce = cpu_exp.pop_front();
        if (ce.is_read != cpu_read || (ce.is_read && cpu_readdata !== ce.data)) begin
          errors++;
          $display("FAIL cpu_resp: got read=%0d data=%0h expected read=%0d data=%0h",
                   cpu_read, cpu_readdata, ce.is_read, ce.data);
        end
      end
    end
    if (mem_read && mem_write) both_cnt++;
    if ((mem_read || mem_write) && !prev_req) starts++;
    prev_req = mem_read || mem_write;
    if (mem_read) rd_run++;
    else if (rd_run != 0) begin
      rd_last = rd_run;
      rd_run  = 0;
    end
    if (mem_write) begin
      after_wr = 1'b1;
      gap      = 0;
    end else if (mem_read) begin
      if (after_wr) begin
        wb_gap   = gap;
        after_wr = 1'b0;
      end
    end else if (after_wr) begin
      gap++;
    end
  end

  // Drive one access (called just after a posedge) and hold it until serviced.
  task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output int nbusy, output bit busy_now);
    bit done = 1'b0;
    nbusy = 0;
    cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata; cpu_byteen = be;
    #1 busy_now = cpu_busywait;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (!cpu_busywait) done = 1'b1;
      else nbusy++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: addr %0h still busy, required release within 100 cycles", addr);
    end
    @(posedge clock); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_busywait", 128'(cpu_busywait), 128'(0));
    chk("reset_mem_read", 128'(mem_read), 128'(0));
    chk("reset_mem_write", 128'(mem_write), 128'(0));
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    // Clean read miss on block 1.
    cpu_exp.push_back('{1'b1, 32'h17161514});
    mem_exp.push_back('{1'b0, 28'h0000001, 128'h0});
    cpu_access(1'b1, 1'b0, 32'h00000014, 32'h0, 4'h0, busy, now);
    chk("miss_busy_at_once", 128'(now), 128'(1));
    chk("clean_miss_latency", 128'(busy), 128'(rd_last + 2));

    // Read hit in the same line.
    s = starts;
    cpu_exp.push_back('{1'b1, 32'h1B1A1918});
    cpu_access(1'b1, 1'b0, 32'h00000018, 32'h0, 4'h0, busy, now);
    chk("hit_no_stall", 128'(busy), 128'(0));
    chk("hit_no_traffic", 128'(starts), 128'(s));

    // Byte-masked write hit, then read it back.
    cpu_exp.push_back('{1'b0, 32'h0});
    cpu_access(1'b0, 1'b1, 32'h00000014, 32'hDEADBEEF, 4'b0101, busy, now);
    chk("write_hit_no_stall", 128'(now), 128'(0));
    chk("write_hit_no_traffic", 128'(starts), 128'(s));
    cpu_exp.push_back('{1'b1, 32'h17AD15EF});
    cpu_access(1'b1, 1'b0, 32'h00000014, 32'h0, 4'h0, busy, now);

    // Conflict miss on a dirty line: writeback of block 1 then fetch of block 9.
    mem_exp.push_back('{1'b1, 28'h0000001, 128'h1F1E1D1C_1B1A1918_17AD15EF_13121110});
    mem_exp.push_back('{1'b0, 28'h0000009, 128'h0});
    cpu_exp.push_back('{1'b1, 32'h97969594});
    cpu_access(1'b1, 1'b0, 32'h00000094, 32'h0, 4'h0, busy, now);
    chk("dirty_miss_busy", 128'(now), 128'(1));
    chk("wb_to_alloc_gap_ok", 128'(wb_gap >= 1), 128'(1));
    chk("mem_image_0x14", {96'h0, wb_img[1][63:32]}, 128'h17AD15EF);

    // Read and write together on a miss address: no access.
    s = starts;
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h00000200;
    cpu_writedata = 32'h12345678; cpu_byteen = 4'hF;
    #1 chk("both_no_busy", 128'(cpu_busywait), 128'(0));
    repeat (3) @(posedge clock);
    #1 chk("both_no_traffic", 128'(starts), 128'(s));
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(posedge clock); #1;
    cpu_exp.push_back('{1'b1, 32'h97969594});
    cpu_access(1'b1, 1'b0, 32'h00000094, 32'h0, 4'h0, busy, now);
    chk("hit_after_both", 128'(now), 128'(0));

    // Reset during ALLOCATE abandons the fetch and invalidates every line.
    cpu_read = 1'b1; cpu_address = 32'h00000300;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (mem_read) seen = 1'b1;
    end
    chk("alloc_started", 128'(seen), 128'(1));
    reset = 1'b1;
    #1;
    chk("reset_drops_mem_read", 128'(mem_read), 128'(0));
    chk("reset_drops_busy", 128'(cpu_busywait), 128'(0));
    cpu_read = 1'b0;
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    mem_exp.push_back('{1'b0, 28'h0000009, 128'h0});
    cpu_exp.push_back('{1'b1, 32'h97969594});
    cpu_access(1'b1, 1'b0, 32'h00000094, 32'h0, 4'h0, busy, now);
    chk("miss_after_reset", 128'(now), 128'(1));

    repeat (3) @(posedge clock);
    #1;
    chk("cpu_exp_drained", 128'(cpu_exp.size()), 128'(0));
    chk("mem_exp_drained", 128'(mem_exp.size()), 128'(0));
    chk("never_read_and_write", 128'(both_cnt), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the RV32IM pipeline MEM stage and the 128-bit block data memory.
- Initiator side of the block-memory read/write/busywait protocol: issues 16-byte block writebacks and fetches, and holds them until the memory drops busywait.
- Presents a 32-bit word interface with byte enables to the CPU, and stalls the pipeline via cpu_busywait on a miss.

Parameters:
- LINES, 8, number of cache lines (power of 2); index width IDX = log2(LINES).
- TAG_W, 25, tag width = 28 - IDX (address[31:4+IDX]).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_read  in  1  word read request
- cpu_write  in  1  write request
- cpu_address  in  32  byte address; bits [1:0] ignored
- cpu_writedata  in  32  store data, already lane-aligned
- cpu_byteen  in  4  write byte enables; bit k enables byte lane k
- cpu_readdata  out  32  word read from the hit line
- cpu_busywait  out  1  stall request to the pipeline
- mem_read  out  1  block fetch request
- mem_write  out  1  block writeback request
- mem_address  out  28  block address (byte address >> 4)
- mem_writedata  out  128  victim line data
- mem_readdata  in  128  fetched block
- mem_busywait  in  1  memory busy

Behaviour:
- Address split: offset = cpu_address[3:2] (word in line); index = cpu_address[3+IDX:4]; tag = cpu_address[31:4+IDX].
- Per line: valid, dirty, tag, 128-bit data. Word w occupies data[32w+31:32w].
- hit = valid[index] & (tag[index] == tag).
- Access = cpu_read XOR cpu_write. Both asserted at once is treated as no access: no state change, cpu_busywait = 0.
- Reset (asynchronous, any state):
  - state = IDLE; all valid = 0, all dirty = 0.
  - mem_read = 0, mem_write = 0, cpu_busywait = 0.
  - An in-flight transfer is abandoned and no line is updated. Data arrays are not cleared.
- cpu_readdata = selected word of the indexed line, combinational; don't-care on a miss.
- FSM states: IDLE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE:
  - Read hit: cpu_busywait = 0 combinationally, zero-stall.
  - Write hit: cpu_busywait = 0. At the next posedge, bytes with cpu_byteen = 1 are written into the selected word and dirty = 1.
  - Miss: cpu_busywait = 1 combinationally. At the posedge go to WRITEBACK if valid & dirty on the victim line, else to ALLOCATE.
- WRITEBACK:
  - mem_write = 1; mem_address = {victim tag, index}; mem_writedata = victim line.
  - All outputs are held stable until a posedge samples mem_busywait = 0 with mem_write asserted for at least one full cycle. Then go to ALLOCATE.
- ALLOCATE:
  - mem_read = 1; mem_address = {cpu tag, index}.
  - Same completion rule as WRITEBACK. On completion, latch mem_readdata into the line, go to UPDATE.
- UPDATE:
  - mem_read = mem_write = 0; set tag, valid = 1, dirty = 0; go to IDLE.
  - The request, still held by the stalled CPU, now hits and is serviced as in IDLE.
- mem_read and mem_write are never both 1. Both are deasserted for at least one cycle between WRITEBACK and ALLOCATE, so the memory registers the end of one access and the start of the next.
- cpu_busywait = 1 in every state other than IDLE, and in IDLE on a miss.
- CPU inputs must be held stable while cpu_busywait = 1. The controller does not re-latch them.
- Write miss: block allocated, then the write applied as a hit in IDLE, so the line ends dirty.
- Miss latency: clean miss = 1 + memory latency + 1 cycles; dirty miss adds writeback latency + 1.

Decomposition:
- Shared package dcache_pkg:
  - state enum {IDLE, WRITEBACK, ALLOCATE, UPDATE}.
  - BLOCK_W = 128, WORD_W = 32, OFFSET_W = 4.
  - Address-field slicing functions.
- Sub-module dcache_line_store:
  - Holds valid/dirty/tag/data arrays with async clear of valid/dirty.
  - Ports: index, tag compare/hit, word read, byte-masked word write, full-line fill.
- FSM and mem-side drive stay in data_cache_controller.

Test Plan:
- After reset, cpu_read at 0x00000014 -> cpu_busywait = 1 at once. mem_read = 1 with mem_address = 0x0000001 until busywait drops, one UPDATE cycle, then cpu_busywait = 0. cpu_readdata = bytes 0x14..0x17 of that block.
- Repeat read at 0x00000018 after that fill -> cpu_busywait stays 0, no mem_read or mem_write, data = bytes 0x18..0x1B.
- cpu_write 0xDEADBEEF, byteen 4'b0101, to 0x00000014 (hit) -> one cycle, no memory traffic. Read back gives 0xXXADXXEF with the other bytes unchanged; the line is dirty.
- Read 0x00000094 (index 1, tag 1, conflicting with dirty line 0x00000010):
  - mem_write = 1, mem_address = 0x0000001, mem_writedata = modified line.
  - At least one idle cycle with mem_read = mem_write = 0.
  - mem_read = 1, mem_address = 0x0000009.
  - The memory image at 0x14 shows 0xEF/0xAD bytes.
- Assert cpu_read and cpu_write together on a miss address -> cpu_busywait = 0, no memory request, no state change.
- Assert reset during ALLOCATE -> mem_read = 0 and cpu_busywait = 0 immediately, all lines invalid. The next access to a previously cached address misses.
